// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath: operand widths, the
// neuron state encoding and the 8-bit saturating clamp.
package snn_pkg;

  localparam int CURRENT_W = 8;
  localparam int ACC_W     = 10;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-128);

  typedef enum logic {
    S_INTEGRATE  = 1'b0,
    S_REFRACTORY = 1'b1
  } lif_state_t;

  // Clamp a wide signed sum into the signed 8-bit membrane range.
  function automatic logic signed [CURRENT_W-1:0] sat8(input logic signed [ACC_W-1:0] x);
    if (x > ACC_MAX) begin
      sat8 = {1'b0, {(CURRENT_W-1){1'b1}}};
    end else if (x < ACC_MIN) begin
      sat8 = {1'b1, {(CURRENT_W-1){1'b0}}};
    end else begin
      sat8 = x[CURRENT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational membrane arithmetic: leak, integrate, saturate, threshold
// compare and post-fire value.
// Macro LIF_RESET_SUBTRACT_EN: when defined, a firing neuron keeps the
// excess above threshold (reset by subtraction); otherwise it resets to zero.
module lif_membrane_update
  import snn_pkg::*;
#(
  parameter int THRESHOLD   = 64,
  parameter int DECAY_SHIFT = 3
) (
  input  logic [CURRENT_W-1:0] v_i,
  input  logic [CURRENT_W-1:0] current_i,
  output logic [CURRENT_W-1:0] v_leak_o,
  output logic [CURRENT_W-1:0] v_next_o,
  output logic                 fire_o,
  output logic [CURRENT_W-1:0] v_fire_o
);

  localparam logic signed [CURRENT_W-1:0] THR = CURRENT_W'(THRESHOLD);

  logic signed [CURRENT_W-1:0] v_s;
  logic signed [CURRENT_W-1:0] leaked;
  logic signed [ACC_W-1:0]     sum;
  logic signed [CURRENT_W-1:0] v_sat;

  // Leak always stays between v and 0, so it fits in 8 bits; only the
  // addition of the input current needs the wider accumulator.
  always_comb begin
    v_s    = v_i;
    leaked = v_s - (v_s >>> DECAY_SHIFT);
    sum    = {{(ACC_W-CURRENT_W){leaked[CURRENT_W-1]}}, leaked}
           + {{(ACC_W-CURRENT_W){current_i[CURRENT_W-1]}}, current_i};
    v_sat  = sat8(sum);
    fire_o = (v_sat >= THR);
`ifdef LIF_RESET_SUBTRACT_EN
    v_fire_o = v_sat - THR;
`else
    v_fire_o = '0;
`endif
    v_leak_o = leaked;
    v_next_o = v_sat;
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: per time step (enable) integrates the
// signed input current into a leaky saturating membrane potential, emits a
// one-cycle spike on threshold crossing and then sits out a refractory
// period during which it only leaks.
// Macro LIF_RESET_SUBTRACT_EN selects reset-by-subtraction on fire
// (default: reset to zero).
module lif_neuron
  import snn_pkg::*;
#(
  parameter int THRESHOLD    = 64,
  parameter int DECAY_SHIFT  = 3,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CURRENT_W-1:0] input_current,
  output logic [CURRENT_W-1:0] membrane_potential,
  output logic                 spike,
  output logic                 refractory_busy
);

  localparam logic [3:0] REFRAC_CNT = 4'(REFRAC_STEPS);

  lif_state_t           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [CURRENT_W-1:0] v_q, v_d;
  logic                 spike_q, spike_d;

  logic [CURRENT_W-1:0] v_leak;
  logic [CURRENT_W-1:0] v_next;
  logic [CURRENT_W-1:0] v_fire;
  logic                 fire;

  lif_membrane_update #(
    .THRESHOLD  (THRESHOLD),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_update (
    .v_i      (v_q),
    .current_i(input_current),
    .v_leak_o (v_leak),
    .v_next_o (v_next),
    .fire_o   (fire),
    .v_fire_o (v_fire)
  );

  // Next-state logic: integrate/fire or leak-only, advancing only on enable.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    spike_d = 1'b0;
    if (enable) begin
      case (state_q)
        S_INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = v_fire;
            cnt_d   = REFRAC_CNT;
            if (REFRAC_STEPS > 0) begin
              state_d = S_REFRACTORY;
            end
          end else begin
            v_d = v_next;
          end
        end
        S_REFRACTORY: begin
          // Input is ignored here; the step that exhausts the counter also
          // only leaks and hands back to integration for the next step.
          v_d = v_leak;
          if (cnt_q <= 4'd1) begin
            cnt_d   = '0;
            state_d = S_INTEGRATE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q <= S_INTEGRATE;
      cnt_q   <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign membrane_potential = v_q;
  assign spike              = spike_q;
  assign refractory_busy    = (state_q == S_REFRACTORY);

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench for lif_neuron. Two instances share the stimulus: the
// default configuration (64/3/2) and a boundary configuration (127/0/0).
// A behavioural model predicts each instance's outputs per clock; a monitor
// pops and compares independently of the driver.
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] input_current;

  logic [7:0] v_a, v_b;
  logic       spk_a, spk_b;
  logic       busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_neuron #(
    .THRESHOLD   (64),
    .DECAY_SHIFT (3),
    .REFRAC_STEPS(2)
  ) dut_a (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .input_current     (input_current),
    .membrane_potential(v_a),
    .spike             (spk_a),
    .refractory_busy   (busy_a)
  );

  lif_neuron #(
    .THRESHOLD   (127),
    .DECAY_SHIFT (0),
    .REFRAC_STEPS(0)
  ) dut_b (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .input_current     (input_current),
    .membrane_potential(v_b),
    .spike             (spk_b),
    .refractory_busy   (busy_b)
  );

  typedef struct {
    int v;
    bit spike;
    bit busy;
    int steps_left;
    int thr;
    int ds;
    int rs;
  } model_t;

  typedef struct {
    int v;
    bit spike;
    bit busy;
  } exp_t;

  model_t ma, mb;
  exp_t   qa[$];
  exp_t   qb[$];

  // Behavioural neuron: one call per clock, plain integer arithmetic.
  function automatic model_t model_step(model_t m, bit rst, bit en, int cur);
    model_t n;
    int     vn;
    n       = m;
    n.spike = 1'b0;
    if (rst) begin
      n.v          = 0;
      n.busy       = 1'b0;
      n.steps_left = 0;
    end else if (en) begin
      if (!m.busy) begin
        vn = m.v - (m.v >>> m.ds) + cur;
        if (vn > 127)  vn = 127;
        if (vn < -128) vn = -128;
        if (vn >= m.thr) begin
          n.spike = 1'b1;
`ifdef LIF_RESET_SUBTRACT_EN
          n.v = vn - m.thr;
`else
          n.v = 0;
`endif
          if (m.rs > 0) begin
            n.busy       = 1'b1;
            n.steps_left = m.rs;
          end
        end else begin
          n.v = vn;
        end
      end else begin
        n.v          = m.v - (m.v >>> m.ds);
        n.steps_left = m.steps_left - 1;
        if (n.steps_left == 0) n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one clock of stimulus and record what each instance should show.
  task automatic step(input bit rst, input bit en, input int cur);
    @(negedge clk);
    reset         = rst;
    enable        = en;
    input_current = 8'(cur);
    ma = model_step(ma, rst, en, cur);
    mb = model_step(mb, rst, en, cur);
    qa.push_back('{v: ma.v, spike: ma.spike, busy: ma.busy});
    qb.push_back('{v: mb.v, spike: mb.spike, busy: mb.busy});
  endtask

  // Monitor: after each rising edge, compare outputs with the oldest prediction.
  bit prev_a = 1'b0;
  bit prev_b = 1'b0;
  always @(posedge clk) begin
    exp_t ea, eb;
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      check("a_v",     int'($signed(v_a)), ea.v);
      check("a_spike", int'(spk_a),        int'(ea.spike));
      check("a_busy",  int'(busy_a),       int'(ea.busy));
      check("a_spike_back_to_back", int'(prev_a && spk_a), 0);
      prev_a = spk_a;
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      check("b_v",     int'($signed(v_b)), eb.v);
      check("b_spike", int'(spk_b),        int'(eb.spike));
      check("b_busy",  int'(busy_b),       int'(eb.busy));
      prev_b = spk_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cur;
    bit rst;
    bit en;
    reset         = 1'b0;
    enable        = 1'b0;
    input_current = '0;
    ma = '{v: 0, spike: 1'b0, busy: 1'b0, steps_left: 0, thr: 64,  ds: 3, rs: 2};
    mb = '{v: 0, spike: 1'b0, busy: 1'b0, steps_left: 0, thr: 127, ds: 0, rs: 0};

    // Reset state.
    step(1, 0, 0);
    step(0, 0, 0);

    // Integrate 20 four times: 20, 38, 54, then fire.
    repeat (4) step(0, 1, 20);

    // Refractory: two leak-only steps, then 100 fires.
    repeat (3) step(0, 1, 100);

    // Negative saturation.
    step(1, 0, 0);
    repeat (3) step(0, 1, -128);

    // Enable low: everything holds, no spike.
    repeat (10) step(0, 0, 127);

    // Reset while refractory, then fire straight away.
    step(1, 0, 0);
    step(0, 1, 70);
    step(1, 0, 0);
    step(0, 1, 70);

    // Threshold boundary for the 127/0/0 instance.
    step(1, 0, 0);
    step(0, 1, 126);
    step(0, 1, 127);
    step(0, 1, 127);
    step(0, 1, -1);

    // Reset mid-run after activity.
    step(0, 1, 50);
    step(1, 1, 50);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 3) != 0);
      cur = int'($urandom_range(0, 255)) - 128;
      step(rst, en, cur);
    end

    step(0, 0, 0);
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) begin
      @(posedge clk);
    end
    #2;
    check("queue_drain", qa.size() + qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
